// File: rtl/des_round_engine.sv
// rtl/des_round_engine.sv - iterative DES Feistel engine, optional IP/FP via DES_ROUND_ENGINE_IP_FP_EN
module des_round_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic        busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
    $error("des_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Bit-index tables use DES numbering: entry n means DES bit n, bit 1 = MSB.
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Each S-box is 64 nibbles, row-major (row = outer bits, col = inner bits), first entry in the MSBs.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [47:0] e_perm(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

`ifdef DES_ROUND_ENGINE_IP_FP_EN
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7};

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25};

  function automatic logic [63:0] load_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] out_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction
`else
  // Without IP/FP the block is passed straight through for external permutation logic.
  function automatic logic [63:0] load_perm(input logic [63:0] x);
    return x;
  endfunction

  function automatic logic [63:0] out_perm(input logic [63:0] x);
    return x;
  endfunction
`endif

  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [5:0]  six;
    logic [31:0] s;
    x = e_perm(r) ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      s[31-4*b -: 4] = SBOX[b][255 - 4*int'({six[5], six[0], six[4:1]}) -: 4];
    end
    return p_perm(s);
  endfunction

  // Left-shift amount for 0-based round index idx (1 for rounds 1, 2, 9, 16).
  function automatic logic [1:0] shift_amt(input logic [4:0] idx);
    return (idx == 5'd0 || idx == 5'd1 || idx == 5'd8 || idx == 5'd15) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic [63:0] out_block_q, out_block_d;

  logic [31:0] l_rnd, r_rnd;
  logic [27:0] c_rnd, d_rnd;
  logic [4:0]  cnt_step;
  logic        last_step;

  assign cnt_step  = cnt_q + 5'(ROUNDS_PER_CYCLE);
  assign last_step = (cnt_step == 5'd16);
  assign out_block = out_block_q;

  // Unrolled rounds for this cycle; decrypt walks the key schedule backwards from C0/D0.
  always_comb begin
    logic [31:0] l_v, r_v, t_v;
    logic [27:0] c_v, d_v;
    logic [4:0]  rnd_v;
    logic [1:0]  sh_v;
    l_v = l_q;
    r_v = r_q;
    c_v = c_q;
    d_v = d_q;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      rnd_v = cnt_q + 5'(j);
      if (dec_q) begin
        sh_v = (rnd_v == 5'd0) ? 2'd0 : shift_amt(5'd16 - rnd_v);
        c_v  = rotr28(c_v, sh_v);
        d_v  = rotr28(d_v, sh_v);
      end else begin
        sh_v = shift_amt(rnd_v);
        c_v  = rotl28(c_v, sh_v);
        d_v  = rotl28(d_v, sh_v);
      end
      t_v = r_v;
      r_v = l_v ^ f_fn(r_v, pc2_perm({c_v, d_v}));
      l_v = t_v;
    end
    l_rnd = l_v;
    r_rnd = r_v;
    c_rnd = c_v;
    d_rnd = d_v;
  end

  // FSM next state and the state-decoded handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = ROUND;
      end
      ROUND: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: load on accept, advance during ROUND, capture result on the last step.
  always_comb begin
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    dec_d       = dec_q;
    out_block_d = out_block_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          {l_d, r_d} = load_perm(in_block);
          {c_d, d_d} = pc1_perm(in_key);
          dec_d      = in_decrypt;
          cnt_d      = 5'd0;
        end
      end
      ROUND: begin
        l_d   = l_rnd;
        r_d   = r_rnd;
        c_d   = c_rnd;
        d_d   = d_rnd;
        cnt_d = cnt_step;
        if (last_step) out_block_d = out_perm({r_rnd, l_rnd});
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers; all cleared by reset so an aborted block leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      out_block_q <= '0;
    end else begin
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      out_block_q <= out_block_d;
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// tb/tb_des_round_engine.sv - directed self-checking bench for des_round_engine
module tb_des_round_engine;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
`ifdef DES_ROUND_ENGINE_IP_FP_EN
  localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
  localparam logic [63:0] PT2 = 64'h8787878787878787;
  localparam logic [63:0] CT2 = 64'h0000000000000000;
`else
  // IP(0123456789ABCDEF), IP(85E813540F0AB405), IP(8787878787878787), IP(0)
  localparam logic [63:0] PT1 = 64'hCC00CCFFF0AAF0AA;
  localparam logic [63:0] CT1 = 64'h0A4CD99543423234;
  localparam logic [63:0] PT2 = 64'h0000FFFFFF0000FF;
  localparam logic [63:0] CT2 = 64'h0000000000000000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
  logic [63:0] in_block, in_key, out_block;

  logic             xin_valid, xout_ready;
  logic [3:0]       x_in_ready, x_out_valid, x_busy;
  logic [3:0][63:0] x_out_block;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int lat;
  int xlat [4];
  int acc2_edge;
  int nres;
  int k;
  logic [63:0] res [2];

  always #5 clk = ~clk;

  des_round_engine #(.ROUNDS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy));

  for (genvar g = 0; g < 4; g++) begin : g_x
    des_round_engine #(.ROUNDS_PER_CYCLE(2 << g)) u_x (
      .clk(clk), .rst_n(rst_n), .in_valid(xin_valid), .in_ready(x_in_ready[g]),
      .in_block(in_block), .in_key(in_key), .in_decrypt(in_decrypt),
      .out_valid(x_out_valid[g]), .out_ready(xout_ready), .out_block(x_out_block[g]),
      .busy(x_busy[g]));
  end

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one block to the main engine; returns at the negedge after the accept edge.
  task automatic accept_main(input logic [63:0] blk, input logic [63:0] key, input logic dec);
    @(negedge clk);
    in_block   = blk;
    in_key     = key;
    in_decrypt = dec;
    in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen; bounded at 40.
  task automatic wait_result(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!out_valid && edges < 40);
  endtask

  task automatic consume_main();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; xin_valid = 1'b0; out_ready = 1'b0; xout_ready = 1'b0;
    in_block = '0; in_key = '0; in_decrypt = 1'b0;
    #2;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk64("rst_out_block", out_block, 64'h0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk64("rst_x_out_valid", 64'(x_out_valid), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Encrypt, RPC=1
    accept_main(PT1, K1, 1'b0);
    chk1("busy_after_accept", busy, 1'b1);
    chk1("in_ready_after_accept", in_ready, 1'b0);
    wait_result(lat);
    chki("enc_latency", lat, 16);
    chk64("enc_block", out_block, CT1);
    consume_main();
    chk1("valid_cleared", out_valid, 1'b0);
    chk64("block_kept", out_block, CT1);
    chk1("in_ready_back", in_ready, 1'b1);

    // Decrypt, RPC=1
    accept_main(CT1, K1, 1'b1);
    wait_result(lat);
    chki("dec_latency", lat, 16);
    chk64("dec_block", out_block, PT1);
    consume_main();

    // Asynchronous reset during round 7
    accept_main(PT1, K1, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk1("pre_reset_in_ready", in_ready, 1'b0);
    chk64("pre_reset_out_block", out_block, PT1);
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk64("midrst_out_block", out_block, 64'h0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    accept_main(PT1, K1, 1'b0);
    wait_result(lat);
    chki("post_rst_latency", lat, 16);
    chk64("post_rst_block", out_block, CT1);
    consume_main();

    // RPC = 2, 4, 8, 16 engines, encrypt then decrypt
    for (int dir = 0; dir < 2; dir++) begin
      @(negedge clk);
      in_block   = (dir == 1) ? CT1 : PT1;
      in_key     = K1;
      in_decrypt = (dir == 1);
      xin_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      xin_valid = 1'b0;
      for (int g = 0; g < 4; g++) xlat[g] = 0;
      for (int e = 1; e <= 20; e++) begin
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 4; g++)
          if (x_out_valid[g] && xlat[g] == 0) xlat[g] = e;
      end
      for (int g = 0; g < 4; g++) begin
        chki($sformatf("rpc%0d_dir%0d_latency", 2 << g, dir), xlat[g], 8 >> g);
        chk64($sformatf("rpc%0d_dir%0d_block", 2 << g, dir), x_out_block[g],
              (dir == 1) ? PT1 : CT1);
      end
      xout_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      xout_ready = 1'b0;
      chk64("x_back_to_idle", 64'(x_in_ready), 64'hF);
    end

    // Stall in DONE for 5 cycles with an ignored in_valid pulse
    accept_main(PT2, K2, 1'b0);
    wait_result(lat);
    chki("k2_latency", lat, 16);
    chk64("k2_block", out_block, CT2);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_block = PT1;
        in_key   = K1;
        in_valid = 1'b1;
      end
      if (i == 2) in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk1($sformatf("stall%0d_out_valid", i), out_valid, 1'b1);
      chk64($sformatf("stall%0d_out_block", i), out_block, CT2);
      chk1($sformatf("stall%0d_in_ready", i), in_ready, 1'b0);
    end
    consume_main();
    chk1("stall_release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk1("ignored_pulse_not_started", busy, 1'b0);
    chk64("ignored_pulse_block_kept", out_block, CT2);

    // Back-to-back with in_valid held high and out_ready = 1
    in_block   = PT1;
    in_key     = K1;
    in_decrypt = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    chk1("b2b_first_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_block  = PT2;
    in_key    = K2;
    k         = 0;
    acc2_edge = 0;
    nres      = 0;
    while (nres < 2 && k < 80) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (acc2_edge != 0 && k == acc2_edge) in_valid = 1'b0;
      if (out_valid) begin
        res[nres] = out_block;
        nres++;
      end
      if (in_valid && in_ready && acc2_edge == 0) acc2_edge = k + 1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chki("b2b_second_accept_edge", acc2_edge, 18);
    chki("b2b_result_count", nres, 2);
    chk64("b2b_first_block", res[0], CT1);
    chk64("b2b_second_block", res[1], CT2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
